multi_zone_motion_timer: RTL and testbench
==========================================

# multi_zone_motion_timer

Multi-channel successor to the single-sensor motion timer: conditions up to CHANNELS raw PIR inputs and runs an independent retriggerable hold timer per channel. The hold time is set at runtime in whole seconds. Sits between the board-level sensor pins and the lighting/main-program control logic. Provides per-zone activity levels, an aggregate activity flag, and single-cycle start/expire strobes for the event logger.

## Interface
Parameters:
- CHANNELS, 4: number of sensor channels (1..16).
- CLK_FREQ, 50_000_000: clk frequency in Hz; sets the 1 s prescaler period.
- HOLD_W, 8: width of the hold_sec input, in seconds.
- DEBOUNCE_CYCLES, 50_000: stable cycles required to accept an input change (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- motion  in  CHANNELS  raw sensor levels, asynchronous to clk.
- chan_en  in  CHANNELS  per-channel enable; 0 forces the channel idle.
- hold_sec  in  HOLD_W  hold time after motion ends, in seconds.
- active  out  CHANNELS  channel in ACTIVE or HOLD.
- any_active  out  1  OR of active, registered.
- start_pulse  out  CHANNELS  one-cycle strobe on IDLE→ACTIVE.
- expire_pulse  out  CHANNELS  one-cycle strobe on HOLD→IDLE by timeout.

## Operation
- All outputs reset to 0.
- All internal state resets to zero or IDLE: synchronizers, filters, counters, prescaler and FSMs.
- Input path, per channel:
  - 2-flop synchronizer produces sync.
  - Debounce filter (see Configuration) produces filt.
- Shared prescaler:
  - Counts 0..CLK_FREQ-1 and wraps.
  - tick is high for one cycle when count = CLK_FREQ-1.
  - Free-running from reset; not restarted by motion.
- Per-channel FSM, with hold_cnt of HOLD_W bits:
  - IDLE: if filt=1 and chan_en=1 → ACTIVE; pulse start_pulse.
  - ACTIVE: while filt=1, stay. When filt=0 → HOLD and load hold_cnt ← hold_sec.
  - ACTIVE with hold_sec = 0: when filt=0 → IDLE directly; pulse expire_pulse.
  - HOLD: if filt=1 → ACTIVE (retrigger); no start_pulse; hold_cnt is discarded.
  - HOLD, on tick: if hold_cnt = 1 → IDLE and pulse expire_pulse; otherwise hold_cnt ← hold_cnt−1.
  - Any state with chan_en=0: → IDLE next cycle; no strobes. This takes priority over all other transitions.
- active[i] = (state ≠ IDLE), registered together with the state.
- hold_sec is sampled only on the ACTIVE→HOLD transition; later changes do not affect a running hold.

## Timing
- Latency from motion edge to active change:
  - With debounce: 2 + DEBOUNCE_CYCLES + 1 clk edges.
  - Without debounce: 3 clk edges.
- start_pulse asserts in the same cycle active rises.
- expire_pulse asserts in the same cycle active falls.
- any_active lags active by 1 cycle.
- Hold duration is measured from the ACTIVE→HOLD cycle to the fall of active:
  - Range: (hold_sec−1)·CLK_FREQ+1 to hold_sec·CLK_FREQ cycles, because tick phase is shared.
- If tick coincides with the ACTIVE→HOLD transition, that tick is not counted.
- If filt rises in the same cycle as the expiring tick, retrigger wins: the channel goes to ACTIVE with no expire_pulse.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- Asserting reset mid-hold clears everything immediately, with no strobes.
- On reset release, a channel whose input is already high starts after the normal latency, with start_pulse.

## Configuration
- MZMT_DEBOUNCE_EN defined:
  - Per-channel counter of width clog2(DEBOUNCE_CYCLES+1).
  - Increments each cycle while sync ≠ filt; clears when sync = filt.
  - When it reaches DEBOUNCE_CYCLES−1 with sync ≠ filt still true: filt ← sync and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Not defined: filt = sync. No counter logic is synthesized and DEBOUNCE_CYCLES is ignored.

## Test plan
Benches use CLK_FREQ=10, DEBOUNCE_CYCLES=4, CHANNELS=4, HOLD_W=8, with MZMT_DEBOUNCE_EN defined unless stated.
- motion[0] high for 20 cycles then low, hold_sec=3:
  - start_pulse[0] and active[0] rise exactly 7 edges after the rise.
  - After the fall, active[0] stays high 21–30 cycles, then expire_pulse[0] for 1 cycle.
  - any_active follows 1 cycle later.
- motion[1] glitch of 3 cycles high → no activity on channel 1. Without the macro, the same glitch starts the channel 3 edges later.
- Retrigger in HOLD: motion[2] high again after 1.5 s of hold → active[2] stays high, with no start_pulse and no expire_pulse. A full new hold starts after the second fall.
- hold_sec=0 → active falls and expire_pulse fires on the cycle after filt falls. A hold_sec change during HOLD does not alter the remaining hold.
- chan_en[3] dropped during HOLD → active[3] clears next cycle with no expire_pulse. While chan_en[3]=0, motion[3] is ignored.
- Reset asserted mid-hold on all channels with motion still high:
  - All outputs are 0 immediately.
  - After release, start_pulse fires for all channels on the same cycle, 7 edges later.

Source files
------------

// File: rtl/multi_zone_motion_timer.sv
// rtl/multi_zone_motion_timer.sv - per-zone PIR conditioning and retriggerable hold timers
//
// Purpose: conditions CHANNELS raw motion inputs (2-flop sync + optional
// debounce) and runs an independent IDLE/ACTIVE/HOLD timer per channel,
// counting the hold in whole seconds off a shared 1 s prescaler.
//
// Optional feature macro: MZMT_DEBOUNCE_EN (defined = debounce filter present,
// undefined = filt follows the synchronizer output directly).
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   motion        in   [CHANNELS] raw sensor levels (asynchronous)
//   chan_en       in   [CHANNELS] per-channel enable, 0 forces IDLE
//   hold_sec      in   [HOLD_W] hold time after motion ends, seconds
//   active        out  [CHANNELS] channel in ACTIVE or HOLD
//   any_active    out  registered OR of active (one cycle behind)
//   start_pulse   out  [CHANNELS] one-cycle strobe on IDLE->ACTIVE
//   expire_pulse  out  [CHANNELS] one-cycle strobe on timeout to IDLE

module multi_zone_motion_timer #(
  parameter int CHANNELS        = 4,
  parameter int CLK_FREQ        = 50_000_000,
  parameter int HOLD_W          = 8,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] motion,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic [HOLD_W-1:0]   hold_sec,
  output logic [CHANNELS-1:0] active,
  output logic                any_active,
  output logic [CHANNELS-1:0] start_pulse,
  output logic [CHANNELS-1:0] expire_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  // Two-flop synchronizer
  logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CHANNELS-1:0] filt;

  always_comb begin
    sync1_d = motion;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef MZMT_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0] filt_q, filt_d;
  logic [DW-1:0]       deb_cnt_q [CHANNELS];
  logic [DW-1:0]       deb_cnt_d [CHANNELS];

  // The counter only runs while sync disagrees with filt; the accepting
  // cycle is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < CHANNELS; i++) deb_cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < CHANNELS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  // Shared free-running 1 s prescaler; all channels see the same tick phase,
  // which is why a hold can be up to one second short.
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick = (pre_q == PW'(CLK_FREQ - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Per-channel FSMs; strobes and active are registered with the state
  state_t              state_q    [CHANNELS];
  state_t              state_d    [CHANNELS];
  logic [HOLD_W-1:0]   hold_cnt_q [CHANNELS];
  logic [HOLD_W-1:0]   hold_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] start_q, start_d;
  logic [CHANNELS-1:0] expire_q, expire_d;
  logic                any_active_q, any_active_d;

  always_comb begin
    active_d     = '0;
    start_d      = '0;
    expire_d     = '0;
    any_active_d = |active_q;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]    = state_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      if (!chan_en[i]) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (filt[i]) begin
              state_d[i] = S_ACTIVE;
              start_d[i] = 1'b1;
            end
          end
          S_ACTIVE: begin
            if (!filt[i]) begin
              if (hold_sec == '0) begin
                state_d[i]  = S_IDLE;
                expire_d[i] = 1'b1;
              end else begin
                // hold_sec is captured here only; a tick this cycle is ignored
                state_d[i]    = S_HOLD;
                hold_cnt_d[i] = hold_sec;
              end
            end
          end
          S_HOLD: begin
            // Retrigger has priority over an expiring tick
            if (filt[i]) begin
              state_d[i] = S_ACTIVE;
            end else if (tick) begin
              if (hold_cnt_q[i] == HOLD_W'(1)) begin
                state_d[i]  = S_IDLE;
                expire_d[i] = 1'b1;
              end else begin
                hold_cnt_d[i] = hold_cnt_q[i] - HOLD_W'(1);
              end
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
      active_d[i] = (state_d[i] != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      active_q     <= '0;
      start_q      <= '0;
      expire_q     <= '0;
      any_active_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]    <= S_IDLE;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      pre_q        <= pre_d;
      active_q     <= active_d;
      start_q      <= start_d;
      expire_q     <= expire_d;
      any_active_q <= any_active_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]    <= state_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign active       = active_q;
  assign any_active   = any_active_q;
  assign start_pulse  = start_q;
  assign expire_pulse = expire_q;

endmodule

// File: tb/tb_multi_zone_motion_timer.sv
// tb/tb_multi_zone_motion_timer.sv - scoreboard bench for multi_zone_motion_timer

module tb_multi_zone_motion_timer;

  localparam int CF  = 10;
  localparam int DEB = 4;
`ifdef MZMT_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] motion;
  logic [3:0] chan_en;
  logic [7:0] hold_sec;
  logic [3:0] active;
  logic       any_active;
  logic [3:0] start_pulse;
  logic [3:0] expire_pulse;

  multi_zone_motion_timer #(
    .CHANNELS(4), .CLK_FREQ(CF), .HOLD_W(8), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .motion(motion), .chan_en(chan_en),
    .hold_sec(hold_sec), .active(active), .any_active(any_active),
    .start_pulse(start_pulse), .expire_pulse(expire_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [3:0] ex;
  } ev_t;

  ev_t q[$];
  ev_t mev;
  int  vectors = 0;
  int  errs    = 0;
  int  cyc;
  int  t, k, e, h1, h2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Edge count since reset release; edge n sees a prescaler tick when n%CF==0
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Expire edge for a hold entered at edge hk: the h-th tick strictly after hk
  function automatic int exp_cyc(input int hk, input int h);
    return ((hk / CF) + 1) * CF + (h - 1) * CF;
  endfunction

  function automatic void expect_ev(input int c, input logic [3:0] st, input logic [3:0] ex);
    ev_t n;
    n.cyc = c; n.st = st; n.ex = ex;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc == c) begin
        q[i].st = q[i].st | st;
        q[i].ex = q[i].ex | ex;
        return;
      end
      if (q[i].cyc > c) begin
        q.insert(i, n);
        return;
      end
    end
    q.push_back(n);
  endfunction

  // Strobe monitor: every strobe must match the oldest expected event
  always @(negedge clk) begin
    if (!reset) begin
      if ((start_pulse | expire_pulse) != 4'b0) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {start_pulse, expire_pulse}, 8'h00);
        end else begin
          mev = q.pop_front();
          check("strobe_cyc", cyc, mev.cyc);
          check("start_mask", start_pulse, mev.st);
          check("expire_mask", expire_pulse, mev.ex);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        mev = q.pop_front();
        check("missed_strobe", {start_pulse, expire_pulse}, {mev.st, mev.ex});
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) check("wait_timeout", cyc, n);
  endtask

  initial begin
    reset = 1'b1; motion = '0; chan_en = 4'hF; hold_sec = 8'd3;
    @(negedge clk);
    check("rst_active", active, 0);
    check("rst_any", any_active, 0);
    check("rst_start", start_pulse, 0);
    check("rst_expire", expire_pulse, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic hold on channel 0
    t = 5;
    wait_cyc(t); motion[0] = 1'b1; expect_ev(t + LAT, 4'b0001, 4'b0);
    wait_cyc(t + LAT - 1); check("ch0_pre_rise", active[0], 0);
    wait_cyc(t + LAT);     check("ch0_rise", active, 4'b0001); check("any_lag_rise", any_active, 0);
    wait_cyc(t + LAT + 1); check("any_rise", any_active, 1);
    wait_cyc(t + 20); motion[0] = 1'b0;
    k = t + 20 + LAT; e = exp_cyc(k, 3); expect_ev(e, 4'b0, 4'b0001);
    wait_cyc(e - 1); check("ch0_hold_high", active[0], 1);
    wait_cyc(e);     check("ch0_fall", active[0], 0); check("any_lag_fall", any_active, 1);
    wait_cyc(e + 1); check("any_fall", any_active, 0);

    // Three-cycle glitch on channel 1
    t = e + 5;
    wait_cyc(t); motion[1] = 1'b1;
    wait_cyc(t + 3); motion[1] = 1'b0;
`ifdef MZMT_DEBOUNCE_EN
    wait_cyc(t + LAT + 6); check("glitch_rejected", active[1], 0);
    e = t + LAT + 6;
`else
    expect_ev(t + LAT, 4'b0010, 4'b0);
    e = exp_cyc(t + 3 + LAT, 3); expect_ev(e, 4'b0, 4'b0010);
    wait_cyc(t + LAT); check("glitch_passes", active[1], 1);
    wait_cyc(e + 1);   check("glitch_expired", active[1], 0);
`endif

    // Retrigger in HOLD on channel 2: filt rises 1.5 s into the hold
    t = e + 5;
    wait_cyc(t); motion[2] = 1'b1; expect_ev(t + LAT, 4'b0100, 4'b0);
    wait_cyc(t + 10); motion[2] = 1'b0; h1 = t + 10 + LAT;
    wait_cyc(h1 + 15 - LAT); motion[2] = 1'b1;
    wait_cyc(exp_cyc(h1, 3)); check("retrig_held", active[2], 1);
    wait_cyc(h1 + 32); motion[2] = 1'b0; h2 = h1 + 32 + LAT;
    e = exp_cyc(h2, 3); expect_ev(e, 4'b0, 4'b0100);
    wait_cyc(e - 1); check("retrig_full_hold", active[2], 1);
    wait_cyc(e + 1); check("retrig_done", active[2], 0);

    // hold_sec = 0: drop to IDLE the cycle after filt falls
    hold_sec = 8'd0;
    t = e + 5;
    wait_cyc(t); motion[0] = 1'b1; expect_ev(t + LAT, 4'b0001, 4'b0);
    wait_cyc(t + 10); motion[0] = 1'b0; expect_ev(t + 10 + LAT, 4'b0, 4'b0001);
    wait_cyc(t + 10 + LAT - 1); check("h0_still_active", active[0], 1);
    wait_cyc(t + 10 + LAT);     check("h0_fall", active[0], 0);

    // hold_sec changed mid-hold does not alter the running hold
    hold_sec = 8'd3;
    t = t + 20 + LAT;
    wait_cyc(t); motion[0] = 1'b1; expect_ev(t + LAT, 4'b0001, 4'b0);
    wait_cyc(t + 10); motion[0] = 1'b0; k = t + 10 + LAT;
    e = exp_cyc(k, 3); expect_ev(e, 4'b0, 4'b0001);
    wait_cyc(k + 3); hold_sec = 8'd8;
    wait_cyc(e - 1); check("hchg_high", active[0], 1);
    wait_cyc(e);     check("hchg_fall", active[0], 0);
    hold_sec = 8'd3;

    // chan_en[3] dropped during HOLD
    t = e + 5;
    wait_cyc(t); motion[3] = 1'b1; expect_ev(t + LAT, 4'b1000, 4'b0);
    wait_cyc(t + 10); motion[3] = 1'b0; k = t + 10 + LAT;
    wait_cyc(k + 5); check("en_hold_active", active[3], 1); chan_en[3] = 1'b0;
    wait_cyc(k + 6); check("en_drop_idle", active[3], 0);
    wait_cyc(k + 10); motion[3] = 1'b1;
    wait_cyc(k + 10 + LAT + 5); check("en_off_ignored", active[3], 0);
    motion[3] = 1'b0;
    wait_cyc(k + 20 + 2 * LAT); chan_en[3] = 1'b1;
    wait_cyc(k + 25 + 2 * LAT); check("en_back_idle", active[3], 0);

    // Reset mid-hold with motion held high
    t = k + 30 + 2 * LAT;
    wait_cyc(t); motion = 4'hF; expect_ev(t + LAT, 4'hF, 4'b0);
    wait_cyc(t + 10); motion = 4'b1100;
    wait_cyc(t + 10 + LAT + 5);
    check("all_active_pre_rst", active, 4'hF);
    check("q_empty_pre_rst", q.size(), 0);
    motion = 4'hF;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_active", active, 0);
    check("rst_mid_any", any_active, 0);
    check("rst_mid_strobes", {start_pulse, expire_pulse}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    expect_ev(LAT, 4'hF, 4'b0);
    wait_cyc(LAT - 1); check("post_rst_pre", active, 0);
    wait_cyc(LAT);     check("post_rst_rise", active, 4'hF);
    wait_cyc(LAT + 1); check("post_rst_any", any_active, 1);
    wait_cyc(20); motion = 4'h0;
    e = exp_cyc(20 + LAT, 3); expect_ev(e, 4'b0, 4'hF);
    wait_cyc(e + 2);
    check("final_idle", active, 0);
    check("final_any", any_active, 0);
    check("q_empty_end", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
